// File: rtl/flit_demux_1to5.sv
// Head-flit steered 1-to-5 wormhole demux with a single shared output register.
// Optional FLIT_DEMUX_DROP_CNT_EN adds a saturating drop counter output.
module flit_demux_1to5 #(
  parameter int FLIT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic [0:4]        out_valid,
  input  logic [0:4]        out_ready,
  output logic              busy,
  output logic              drop_pulse
`ifdef FLIT_DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } state_t;

  state_t state_q, state_d;
  logic              hold_valid_q, hold_valid_d;
  logic [2:0]        hold_port_q, hold_port_d;
  logic [2:0]        route_port_q, route_port_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic              drop_pulse_q, drop_pulse_d;

  logic [1:0] typ;
  logic [2:0] sel;
  logic       is_head;
  logic       sel_ok;
  logic       pop;
  logic       accept;

  assign typ     = in_flit[FLIT_W-1 -: 2];
  assign sel     = in_flit[2:0];
  assign is_head = typ[0];
  assign sel_ok  = (sel <= 3'd4);

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < 5; i++) begin
      out_valid[i] = hold_valid_q && (hold_port_q == 3'(i));
    end
  end

  assign pop      = |(out_valid & out_ready);
  // DROP never loads the register, so it can sink flits regardless of output
  assign in_ready = (state_q == DROP) || !hold_valid_q || pop;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q && !pop;
    hold_port_d  = hold_port_q;
    route_port_d = route_port_q;
    out_flit_d   = out_flit_q;
    drop_pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_head && sel_ok: begin
              hold_valid_d = 1'b1;
              hold_port_d  = sel;
              route_port_d = sel;
              out_flit_d   = in_flit;
              if (typ == 2'b01) state_d = FWD;
            end
            is_head && !sel_ok: begin
              drop_pulse_d = 1'b1;
              if (typ == 2'b01) state_d = DROP;
            end
            !is_head: begin
              drop_pulse_d = 1'b1;
            end
          endcase
        end
      end
      FWD: begin
        if (accept) begin
          hold_valid_d = 1'b1;
          hold_port_d  = route_port_q;
          out_flit_d   = in_flit;
          if (typ == 2'b10) state_d = IDLE;
        end
      end
      DROP: begin
        if (accept && typ[1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_port_q  <= 3'd0;
      route_port_q <= 3'd0;
      out_flit_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_port_q  <= hold_port_d;
      route_port_q <= route_port_d;
      out_flit_q   <= out_flit_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  assign out_flit   = out_flit_q;
  assign busy       = (state_q == FWD) || (state_q == DROP);
  assign drop_pulse = drop_pulse_q;

`ifdef FLIT_DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_pulse_q && (drop_cnt_q != 8'hff)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_flit_demux_1to5.sv
// Scoreboard bench for flit_demux_1to5: directed packets, backpressure,
// drops, back-to-back packets and mid-packet reset.
module tb_flit_demux_1to5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_flit;
  logic [0:4]  out_valid;
  logic [0:4]  out_ready = 5'b11111;
  logic        busy;
  logic        drop_pulse;
`ifdef FLIT_DEMUX_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  flit_demux_1to5 #(.FLIT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .drop_pulse (drop_pulse)
`ifdef FLIT_DEMUX_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] flit;
    int          port;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nbad = 0;
  int   ndrop = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] typ,
                                     input logic [2:0] sel,
                                     input logic [7:0] tag);
    return {typ, 19'h0, tag, sel};
  endfunction

  function automatic logic [0:4] onehot(input int p);
    logic [0:4] v;
    v = '0;
    if (p >= 0 && p < 5) v[p] = 1'b1;
    return v;
  endfunction

  // send one flit; exp_port < 0 means the flit must not be emitted
  task automatic send(input logic [31:0] f, input int exp_port,
                      output int waits);
    exp_t e;
    bit   done;
    waits = 0;
    done  = 0;
    in_flit  = f;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        if (exp_port >= 0) begin
          e.flit = f;
          e.port = exp_port;
          sb.push_back(e);
        end
      end else begin
        waits++;
        if (waits > 50) begin
          nvec++;
          nbad++;
          $display("FAIL accept_timeout: flit %0h never accepted", f);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    fork
      begin
        automatic logic [0:4] ev = onehot(exp_port);
        @(negedge clk);
        chk("latency_out_valid", 32'(out_valid), 32'(ev));
      end
    join_none
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid != 5'b0) begin
        int p;
        exp_t e;
        p = 0;
        for (int i = 0; i < 5; i++) if (out_valid[i]) p = i;
        chk("onehot", 32'(out_valid), 32'(onehot(p)));
        if (out_ready[p]) begin
          if (sb.size() == 0) begin
            nvec++;
            nbad++;
            $display("FAIL unexpected_out: got %0h on port %0d expected none",
                     out_flit, p);
          end else begin
            e = sb.pop_front();
            chk("sb_flit", out_flit, e.flit);
            chk("sb_port", 32'(p), 32'(e.port));
          end
        end
      end
      if (drop_pulse) ndrop++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int d0;
    rst_n = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_out_flit", out_flit, 32'h0);
    chk("rst_drop", 32'(drop_pulse), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // route to E
    send(mk(2'b01, 3'd2, 8'h11), 2, w);
    chk("e_busy_head", 32'(busy), 32'h1);
    send(mk(2'b00, 3'd0, 8'h12), 2, w);
    send(mk(2'b00, 3'd0, 8'h13), 2, w);
    chk("e_busy_body", 32'(busy), 32'h1);
    send(mk(2'b10, 3'd0, 8'h14), 2, w);
    chk("e_busy_tail", 32'(busy), 32'h0);
    chk("e_no_stall", 32'(w), 32'h0);
    idle(3);

    // backpressure on W
    send(mk(2'b01, 3'd4, 8'h21), 4, w);
    send(mk(2'b00, 3'd0, 8'h22), 4, w);
    out_ready = 5'b11110;
    fork
      send(mk(2'b00, 3'd0, 8'h23), 4, w);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(in_ready), 32'h0);
          chk("bp_out_flit", out_flit, mk(2'b00, 3'd0, 8'h22));
          @(posedge clk);
          #1;
        end
        out_ready = 5'b11111;
      end
    join
    chk("bp_waits", 32'(w), 32'h3);
    send(mk(2'b10, 3'd0, 8'h24), 4, w);
    chk("bp_resume", 32'(w), 32'h0);
    idle(3);

    // invalid select
    d0 = ndrop;
    send(mk(2'b01, 3'd6, 8'h31), -1, w);
    chk("inv_ready", 32'(w), 32'h0);
    chk("inv_busy", 32'(busy), 32'h1);
    send(mk(2'b00, 3'd0, 8'h32), -1, w);
    chk("inv_ready", 32'(w), 32'h0);
    send(mk(2'b00, 3'd0, 8'h33), -1, w);
    chk("inv_ready", 32'(w), 32'h0);
    send(mk(2'b10, 3'd0, 8'h34), -1, w);
    chk("inv_ready", 32'(w), 32'h0);
    chk("inv_idle", 32'(busy), 32'h0);
    idle(3);
    chk("inv_drops", 32'(ndrop - d0), 32'h1);

    // back-to-back: single-flit local then head N
    send(mk(2'b11, 3'd0, 8'h41), 0, w);
    chk("b2b_idle", 32'(busy), 32'h0);
    send(mk(2'b01, 3'd1, 8'h42), 1, w);
    chk("b2b_no_gap", 32'(w), 32'h0);
    send(mk(2'b10, 3'd5, 8'h43), 1, w);
    idle(3);

    // stray body flit
    d0 = ndrop;
    send(mk(2'b00, 3'd2, 8'h51), -1, w);
    idle(3);
    chk("stray_drops", 32'(ndrop - d0), 32'h1);
    chk("stray_idle", 32'(busy), 32'h0);

    // reset mid-packet with a held flit
    out_ready = 5'b00000;
    send(mk(2'b01, 3'd3, 8'h61), 3, w);
    @(posedge clk);
    #3;
    chk("pre_rst_busy", 32'(busy), 32'h1);
    chk("pre_rst_valid", 32'(out_valid), 32'(onehot(3)));
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_flit", out_flit, 32'h0);
    chk("mid_rst_drop", 32'(drop_pulse), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 5'b11111;
    idle(1);
    d0 = ndrop;
    send(mk(2'b00, 3'd3, 8'h62), -1, w);
    idle(3);
    chk("post_rst_stray", 32'(ndrop - d0), 32'h1);

`ifdef FLIT_DEMUX_DROP_CNT_EN
    for (int k = 0; k < 300; k++) send(mk(2'b00, 3'd0, 8'h70), -1, w);
    idle(3);
    chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);
`endif

    idle(2);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
